eff_delay_var: RTL and testbench

Echo/delay effect with a runtime-programmable delay length and decay.
- Transfer function: y[n] = sat(x[n] + floor(g·y[n−D] / 2^GAIN_WIDTH)).
- Echo history is held in a circular sample buffer (block RAM) of 2^ADDR_WIDTH words.
- Sits in the effect chain between the sampled-audio source and the next effect stage, using the same data/valid sample interface.
- On reset the block clears its history before accepting samples.

---
 rtl/eff_pkg.sv | 45 ++++
 rtl/sdp_ram.sv | 47 ++++
 rtl/eff_delay_var.sv | 234 +++++++++++++++++++++++
 tb/tb_eff_delay_var.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/eff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eff_pkg
//  Description : Shared types, constants and helpers for the echo/delay effect.
//                - state_e  : buffer-clear / running state of the delay block
//                - LATENCY  : input-strobe to output-strobe latency in cycles;
//                             also the number of cycles after an accepted
//                             sample during which new strobes are rejected
//                - sat_add  : signed add clamped to a two's-complement width
//  Revision    : 1.0  initial release
// ============================================================================
package eff_pkg;

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam int LATENCY = 3;

   // Adds two signed values and clamps the result to the range of a signed
   // number of 'width' bits. Works on 32-bit containers, so any width up to
   // 31 is supported; callers truncate the result to 'width' bits.
   function automatic logic signed [31:0] sat_add(
      input logic signed [31:0] a,
      input logic signed [31:0] b,
      input int unsigned        width
   );
      logic signed [31:0] sum;
      logic signed [31:0] max_v;
      logic signed [31:0] min_v;
      sum   = a + b;
      max_v = (32'sd1 <<< (width - 1)) - 32'sd1;
      min_v = -(32'sd1 <<< (width - 1));
      if (sum > max_v) begin
         return max_v;
      end
      if (sum < min_v) begin
         return min_v;
      end
      return sum;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sdp_ram
//  Description : Simple dual-port RAM, one write port and one read port on a
//                single clock. Read data is registered (one-cycle latency).
//                The storage array has no reset; the owner clears it.
//  Ports       : clk    - clock
//                we     - write enable
//                waddr  - write address
//                wdata  - write data
//                raddr  - read address (sampled every cycle)
//                rdata  - registered read data
//  Revision    : 1.0  initial release
// ============================================================================
module sdp_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [DATA_WIDTH-1:0] rd_data_d;
   logic [DATA_WIDTH-1:0] rd_data_q;

   always_comb begin
      rd_data_d = mem[raddr];
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rd_data_q <= rd_data_d;
   end

   assign rdata = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/eff_delay_var.sv
`default_nettype none
// ============================================================================
//  Module      : eff_delay_var
//  Description : Echo/delay effect with runtime delay length and decay.
//                y[n] = sat(x[n] + floor(g * y[n-D] / 2^GAIN_WIDTH))
//                Echo history lives in a circular buffer of 2^ADDR_WIDTH
//                samples that is zero-filled after every reset.
//  Ports       : clk        - system clock
//                rst        - synchronous active-high reset
//                en         - 1 = echo on, 0 = dry pass-through
//                delay_len  - delay D in samples (0 behaves as 1)
//                decay      - feedback gain numerator g
//                data_i     - signed input sample
//                vld_i      - input strobe
//                data_o     - signed output sample (held between strobes)
//                vld_o      - output strobe, 3 cycles after accepted vld_i
//                busy_o     - buffer clear in progress
//                drop_o     - registered pulse, the cycle after a rejected
//                             vld_i (during clear or too close to the
//                             previous accepted sample)
//  Revision    : 1.0  initial release
// ============================================================================
module eff_delay_var #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int GAIN_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [ADDR_WIDTH-1:0] delay_len,
   input  logic [GAIN_WIDTH-1:0] decay,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  vld_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  vld_o,
   output logic                  busy_o,
   output logic                  drop_o
);

   import eff_pkg::*;

   localparam int PROD_WIDTH = DATA_WIDTH + GAIN_WIDTH + 1;
   localparam int GAP_WIDTH  = $clog2(LATENCY + 1);

   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [GAP_WIDTH-1:0]  GAP_LOAD  = GAP_WIDTH'(LATENCY);
   localparam logic [GAP_WIDTH-1:0]  GAP_ONE   = GAP_WIDTH'(1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e                         state_q,    state_d;
   logic        [ADDR_WIDTH-1:0]   clr_addr_q, clr_addr_d;
   logic        [ADDR_WIDTH-1:0]   wr_ptr_q,   wr_ptr_d;
   logic        [GAP_WIDTH-1:0]    gap_q,      gap_d;

   // Stage 1: captured sample, controls and read address
   logic                           s1_vld_q,   s1_vld_d;
   logic signed [DATA_WIDTH-1:0]   x_q,        x_d;
   logic        [GAIN_WIDTH-1:0]   g_q,        g_d;
   logic                           en_q,       en_d;
   logic        [ADDR_WIDTH-1:0]   rd_addr_q,  rd_addr_d;

   // Stage 2: RAM read data valid
   logic                           s2_vld_q,   s2_vld_d;

   // Output stage
   logic signed [DATA_WIDTH-1:0]   data_o_q,   data_o_d;
   logic                           vld_o_q,    vld_o_d;
   logic                           drop_q,     drop_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic                           accept;
   logic        [ADDR_WIDTH-1:0]   delay_eff;
   logic signed [GAIN_WIDTH:0]     gain_s;
   logic signed [PROD_WIDTH-1:0]   prod;
   logic signed [PROD_WIDTH-1:0]   prod_shr;
   logic signed [31:0]             echo;

   logic                           ram_we;
   logic        [ADDR_WIDTH-1:0]   ram_waddr;
   logic signed [DATA_WIDTH-1:0]   ram_wdata;
   logic signed [DATA_WIDTH-1:0]   ram_rdata;

   // ------------------------------------------------------------------------
   // Echo history buffer
   // ------------------------------------------------------------------------
   sdp_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (rd_addr_q),
      .rdata (ram_rdata)
   );

   // ------------------------------------------------------------------------
   // Datapath arithmetic
   // ------------------------------------------------------------------------
   always_comb begin
      delay_eff = (delay_len == '0) ? ADDR_ONE : delay_len;

      // Gain is an unsigned numerator; a zero sign bit keeps the product
      // signed so the arithmetic shift floors toward minus infinity.
      gain_s   = {1'b0, g_q};
      prod     = PROD_WIDTH'(ram_rdata) * PROD_WIDTH'(gain_s);
      prod_shr = prod >>> GAIN_WIDTH;
      echo     = en_q ? 32'(prod_shr) : 32'sd0;
   end

   // ------------------------------------------------------------------------
   // Next-state / control
   // ------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      wr_ptr_d   = wr_ptr_q;
      gap_d      = gap_q;
      s1_vld_d   = 1'b0;
      x_d        = x_q;
      g_d        = g_q;
      en_d       = en_q;
      rd_addr_d  = rd_addr_q;
      s2_vld_d   = s1_vld_q;
      data_o_d   = data_o_q;
      vld_o_d    = s2_vld_q;
      ram_we     = 1'b0;
      ram_waddr  = wr_ptr_q;
      ram_wdata  = data_o_q;

      accept = vld_i && (state_q == RUN) && (gap_q == '0);
      drop_d = vld_i && !accept;

      case (state_q)
         CLEAR: begin
            // One zero word per cycle; the ram write is gated by rst below
            // so the sweep starts in the first cycle after reset releases.
            ram_we     = 1'b1;
            ram_waddr  = clr_addr_q;
            ram_wdata  = '0;
            clr_addr_d = clr_addr_q + ADDR_ONE;
            if (clr_addr_q == ADDR_LAST) begin
               state_d = RUN;
            end
         end
         RUN: begin
            // Output sample goes into history in the cycle it is presented.
            ram_we = vld_o_q;
            if (vld_o_q) begin
               wr_ptr_d = wr_ptr_q + ADDR_ONE;
            end
         end
         default: begin
            state_d = CLEAR;
         end
      endcase

      if (rst) begin
         ram_we = 1'b0;
      end

      // Reject window: the counter covers the cycles in which the previous
      // sample has not yet been written back to history.
      if (accept) begin
         gap_d = GAP_LOAD;
      end else if (gap_q != '0) begin
         gap_d = gap_q - GAP_ONE;
      end

      // The stage-1 registers are held until the next accepted sample,
      // which the reject window guarantees is after this one has left
      // the pipeline, so stage 2 reads them directly.
      if (accept) begin
         s1_vld_d  = 1'b1;
         x_d       = data_i;
         g_d       = decay;
         en_d      = en;
         rd_addr_d = wr_ptr_q - delay_eff;
      end

      if (s2_vld_q) begin
         data_o_d = DATA_WIDTH'(sat_add(32'(x_q), echo, DATA_WIDTH));
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= CLEAR;
         clr_addr_q <= '0;
         wr_ptr_q   <= '0;
         gap_q      <= '0;
         s1_vld_q   <= 1'b0;
         x_q        <= '0;
         g_q        <= '0;
         en_q       <= 1'b0;
         rd_addr_q  <= '0;
         s2_vld_q   <= 1'b0;
         data_o_q   <= '0;
         vld_o_q    <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         wr_ptr_q   <= wr_ptr_d;
         gap_q      <= gap_d;
         s1_vld_q   <= s1_vld_d;
         x_q        <= x_d;
         g_q        <= g_d;
         en_q       <= en_d;
         rd_addr_q  <= rd_addr_d;
         s2_vld_q   <= s2_vld_d;
         data_o_q   <= data_o_d;
         vld_o_q    <= vld_o_d;
         drop_q     <= drop_d;
      end
   end

   assign data_o = data_o_q;
   assign vld_o  = vld_o_q;
   assign busy_o = (state_q == CLEAR);
   assign drop_o = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_eff_delay_var.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eff_delay_var
//  Description : Self-checking bench for eff_delay_var (8-bit data, 16-word
//                history, 4-bit gain). A reference model keeps every output
//                since the last clear in a queue and applies the echo
//                equation with plain integer arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_eff_delay_var;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int GW = 4;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic [AW-1:0]        delay_len;
   logic [GW-1:0]        decay;
   logic signed [DW-1:0] data_i;
   logic                 vld_i;
   logic signed [DW-1:0] data_o;
   logic                 vld_o;
   logic                 busy_o;
   logic                 drop_o;

   int errors = 0;
   int checks = 0;
   int ys[$];

   always #5 clk = ~clk;

   eff_delay_var #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .GAIN_WIDTH (GW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .delay_len (delay_len),
      .decay     (decay),
      .data_i    (data_i),
      .vld_i     (vld_i),
      .data_o    (data_o),
      .vld_o     (vld_o),
      .busy_o    (busy_o),
      .drop_o    (drop_o)
   );

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int floor_div(input int a, input int b);
      int q;
      q = a / b;
      if ((a % b) != 0 && ((a < 0) != (b < 0))) q = q - 1;
      return q;
   endfunction

   function automatic int clamp8(input int v);
      if (v > 127)  return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   // Reference: y[n] = sat(x + floor(g * y[n-D] / 16)), history zero before
   // the first sample after a clear, D = 0 behaves as D = 1.
   function automatic int model_step(input int x, input bit e, input int d,
                                     input int g);
      int deff, n, r, y;
      deff = (d == 0) ? 1 : d;
      n    = ys.size();
      r    = (n >= deff) ? ys[n - deff] : 0;
      y    = clamp8(x + (e ? floor_div(r * g, 16) : 0));
      ys.push_back(y);
      return y;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      logic signed [DW-1:0] held;
      held = data_o;
      for (int i = 0; i < n; i++) begin
         tick();
         chk("hold", data_o, held);
      end
   endtask

   // Drives one sample and checks the 3-cycle latency and value. With
   // 'intrude' set, a second strobe is placed 2 cycles after the first.
   task automatic send(input int x, input bit e, input int d, input int g,
                       input bit intrude);
      int expy;
      logic [31:0] xv;
      logic [31:0] dv;
      logic [31:0] gv;
      expy      = model_step(x, e, d, g);
      xv        = x;
      dv        = d;
      gv        = g;
      data_i    = xv[DW-1:0];
      en        = e;
      delay_len = dv[AW-1:0];
      decay     = gv[GW-1:0];
      vld_i     = 1'b1;
      tick();
      vld_i = 1'b0;
      chk("drop_on_accept", drop_o, 0);
      chk("vld_t1", vld_o, 0);
      tick();
      chk("vld_t2", vld_o, 0);
      if (intrude) begin
         vld_i  = 1'b1;
         data_i = 8'sd99;
      end
      tick();
      if (intrude) begin
         vld_i = 1'b0;
         chk("drop_gap", drop_o, 1);
      end
      chk("vld_t3", vld_o, 1);
      chk("data", data_o, expy);
      tick();
   endtask

   // Counts busy cycles starting in the first cycle with rst low.
   task automatic wait_clear(input bit poke);
      int n;
      bit saw_vld;
      n       = 0;
      saw_vld = 1'b0;
      while (busy_o === 1'b1 && n < 100) begin
         if (vld_o !== 1'b0) saw_vld = 1'b1;
         if (poke && n == 5) begin
            vld_i = 1'b0;
            chk("drop_in_clear", drop_o, 1);
         end
         if (poke && n == 4) begin
            data_i = 8'sd55;
            vld_i  = 1'b1;
         end
         n++;
         tick();
      end
      vld_i = 1'b0;
      chk("busy_cycles", n, 16);
      chk("no_vld_in_clear", saw_vld, 0);
      chk("busy_low", busy_o, 0);
      chk("no_vld_after_clear", vld_o, 0);
      ys.delete();
   endtask

   initial begin
      int x, d, g;
      bit e;

      rst       = 1'b1;
      en        = 1'b0;
      delay_len = '0;
      decay     = '0;
      data_i    = '0;
      vld_i     = 1'b0;
      repeat (3) tick();

      chk("rst_busy", busy_o, 1);
      chk("rst_vld", vld_o, 0);
      chk("rst_data", data_o, 0);
      chk("rst_drop", drop_o, 0);

      rst = 1'b0;
      wait_clear(1'b1);
      idle(2);

      // Impulse echo: 64, 0, 0, 32, 0, 0, 16, ...
      send(64, 1, 3, 8, 0);
      for (int i = 0; i < 14; i++) send(0, 1, 3, 8, 0);

      // Negative input with flooring toward minus infinity.
      send(-64, 1, 2, 8, 0);
      for (int i = 0; i < 16; i++) send(0, 1, 2, 8, 0);

      // Saturation at the positive rail.
      for (int i = 0; i < 6; i++) send(100, 1, 1, 15, 0);

      // Dry ramp, then echo of the ramp across the pointer wrap.
      for (int i = 0; i < 40; i++) send(i * 6 - 120, 0, 5, 0, 0);
      for (int i = 0; i < 20; i++) send(0, 1, 15, 8, 0);

      // delay_len = 0 behaves as 1.
      send(80, 1, 0, 8, 0);
      for (int i = 0; i < 4; i++) send(0, 1, 0, 8, 0);

      // Randomized mix, with one gap violation in the middle.
      for (int i = 0; i < 60; i++) begin
         x = int'($urandom_range(0, 255)) - 128;
         e = ($urandom_range(0, 3) != 0);
         d = int'($urandom_range(0, 15));
         g = int'($urandom_range(0, 15));
         send(x, e, d, g, (i == 30));
         idle(int'($urandom_range(0, 2)));
      end

      // Mid-run reset one cycle after a strobe: sample is abandoned.
      data_i    = 8'sd50;
      en        = 1'b1;
      delay_len = 4'd2;
      decay     = 4'd8;
      vld_i     = 1'b1;
      tick();
      vld_i = 1'b0;
      rst   = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_vld", vld_o, 0);
      chk("midrst_busy", busy_o, 1);
      wait_clear(1'b0);

      // After the re-clear, no history from before the reset may echo.
      send(64, 1, 5, 12, 0);
      for (int i = 0; i < 16; i++) send(0, 1, 5, 12, 0);
      send(0, 1, 14, 15, 0);
      send(0, 1, 12, 15, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
